codec_cfg_seq: RTL and testbench
================================

Name: codec_cfg_seq

Overview:
- Parametrised sequencer that powers up and configures the audio codec over the shared two-wire serial controller.
- Walks a configuration table of 16-bit register words, prefixes each with the device address, and issues one serial transaction per word.
- Handshakes with the serial controller, retries on NACK, and supports runtime volume up/down by rewriting only the two headphone-volume registers.
- Sits between the board-level reset/control logic and the serial controller instance.

Parameters:
- CLK_DIV_W, 11, width of the pacing divider; one tick every 2^CLK_DIV_W CLOCK cycles.
- ROM_DEPTH, 9, number of configuration words; the last word is the activate word.
- DEV_ADDR, 8'h34, device write address placed in i2c_data[23:16].
- VOL_IDX_L, 6, table index of the left volume word.
- VOL_IDX_R, 7, table index of the right volume word.
- VOL_DEFAULT, 7'h60, volume after reset.
- VOL_STEP, 5, volume increment/decrement per request.
- TIMEOUT_TICKS, 15, ticks to wait for i2c_end before the transaction is treated as failed.
- MAX_RETRY, 3, retries per word (used only with the optional feature).

Ports:
- CLOCK  in  1  system clock
- RESET  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins the full sequence from IDLE or DONE
- vol_up  in  1  one-cycle pulse; raise volume
- vol_dn  in  1  one-cycle pulse; lower volume
- i2c_end  in  1  one-cycle pulse from the controller: transaction finished
- i2c_ack  in  1  valid with i2c_end; 1 = all bytes ACKed
- i2c_go  out  1  one-cycle pulse: start transaction
- i2c_data  out  24  {DEV_ADDR, word}; stable from i2c_go until i2c_end
- clk_tick  out  1  divider tick, one cycle wide
- busy  out  1  sequence in progress
- done  out  1  all words written successfully
- error  out  1  sticky failure flag
- volume  out  7  current volume code
- idx  out  $clog2(ROM_DEPTH)  current table index

Behaviour:
Reset (RESET=0, asynchronous) forces:
- state IDLE; divider, idx and retry count 0
- i2c_go=0, i2c_data=0, busy=0, done=0, error=0
- volume=VOL_DEFAULT, vol_pending=0

Divider:
- Free-running CLK_DIV_W-bit counter.
- clk_tick=1 for the single cycle in which the counter equals all-ones.

Table:
- word(i) comes from the package constants, except word(VOL_IDX_L)={8'h04,1'b0,volume} and word(VOL_IDX_R)={8'h06,1'b0,volume}.

FSM, one transition per CLOCK unless stated:
- IDLE: on start -> LOAD with idx=0 and mode FULL.
- LOAD: latch i2c_data={DEV_ADDR,word(idx)} -> ISSUE.
- ISSUE: wait for clk_tick; in that cycle pulse i2c_go and clear the timeout counter -> WAIT.
- WAIT:
  - i2c_end with ack=1 -> NEXT.
  - i2c_end with ack=0, or timeout counter reaching TIMEOUT_TICKS (counted on clk_tick) -> FAIL.
- NEXT:
  - FULL mode: if idx==ROM_DEPTH-1 -> DONE, else idx+1 -> LOAD.
  - VOL mode: if idx==VOL_IDX_L then idx=VOL_IDX_R -> LOAD, else -> DONE.
- FAIL: error=1 -> ERR.
- DONE: done=1.
  - start -> full sequence.
  - else vol_pending -> clear vol_pending, idx=VOL_IDX_L, mode VOL -> LOAD.
- ERR: holds until start, which clears error and restarts the full sequence.

Status outputs:
- busy=1 in LOAD, ISSUE, WAIT, NEXT, FAIL.
- done clears on leaving DONE.

Volume:
- vol_up: volume=min(volume+VOL_STEP,127).
- vol_dn: volume=max(volume-VOL_STEP,0), computed 8-bit then saturated.
- Both pulses in the same cycle: ignored.
- Any accepted change sets vol_pending; while busy the request is only recorded and served in DONE.
- A latched i2c_data word is never modified mid-transaction.

Boundary conditions:
- i2c_end outside WAIT: ignored.
- start while busy: ignored.
- Reset mid-transaction: immediate return to IDLE; i2c_go is never left high.

Optional Feature:
Macro CODEC_CFG_RETRY_EN.
- Defined: in WAIT, a NACK or timeout with retry count < MAX_RETRY increments the count and returns to ISSUE, re-sending the same word on the next tick. The count is cleared in NEXT. FAIL is entered only after MAX_RETRY retries.
- Undefined: the first NACK or timeout goes to FAIL; no retry counter is synthesised.

Decomposition:
- Package codec_cfg_pkg holds:
  - state enum (IDLE, LOAD, ISSUE, WAIT, NEXT, FAIL, DONE, ERR)
  - mode enum (FULL, VOL)
  - register address constants (power 8'h0C, path 8'h08, interface 8'h0E, sampling 8'h10, active 8'h12, line L/R 8'h00/8'h02, HP L/R 8'h04/8'h06)
  - default word table: 0C00, 0EC2, 0838, 1000, 0017, 0217, volL, volR, 1201
- One sub-module, codec_cfg_rom: combinational index+volume -> 16-bit word.

Test Plan:
1. Reset, then start, controller always ACKs -> nine i2c_go pulses, each after a clk_tick, with i2c_data 340C00, 340EC2, 340838, 341000, 340017, 340217, 340460, 340660, 341201; done=1; error=0.
2. In DONE, vol_up x7 -> volume saturates at 127 (96, 101, ..., 126, 127); exactly two writes, 34047F then 34067F, per served request.
3. vol_dn while busy during the full sequence -> no extra write until DONE; then 34045B and 34065B; vol_up and vol_dn together -> volume unchanged.
4. NACK on word 3:
   - without macro -> error=1, state ERR, no further i2c_go.
   - with macro -> word 341000 re-sent up to 3 times; ACK on the 2nd retry -> sequence completes.
5. Controller silent -> after 15 ticks, FAIL (or retry with macro); start then clears error and restarts at 340C00.
6. RESET asserted during WAIT of word 5 -> outputs return to reset values in the same cycle; a following start restarts at idx 0.

Source files
------------

// File: rtl/codec_cfg_pkg.sv
// Shared types and constants for the audio codec configuration sequencer.
// Optional retry behaviour in codec_cfg_seq is enabled with CODEC_CFG_RETRY_EN.
package codec_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_NEXT  = 3'd4,
    ST_FAIL  = 3'd5,
    ST_DONE  = 3'd6,
    ST_ERR   = 3'd7
  } state_e;

  typedef enum logic {
    MODE_FULL = 1'b0,
    MODE_VOL  = 1'b1
  } mode_e;

  // Codec register addresses (upper byte of each configuration word)
  localparam logic [7:0] REG_LINE_L   = 8'h00;
  localparam logic [7:0] REG_LINE_R   = 8'h02;
  localparam logic [7:0] REG_HP_L     = 8'h04;
  localparam logic [7:0] REG_HP_R     = 8'h06;
  localparam logic [7:0] REG_PATH     = 8'h08;
  localparam logic [7:0] REG_POWER    = 8'h0C;
  localparam logic [7:0] REG_IFACE    = 8'h0E;
  localparam logic [7:0] REG_SAMPLING = 8'h10;
  localparam logic [7:0] REG_ACTIVE   = 8'h12;

  // Default configuration table; entries 6/7 carry the supplied volume code.
  function automatic logic [15:0] cfg_default_word(input logic [7:0] i, input logic [6:0] vol);
    logic [15:0] w;
    case (i)
      8'd0:    w = {REG_POWER,    8'h00};
      8'd1:    w = {REG_IFACE,    8'hC2};
      8'd2:    w = {REG_PATH,     8'h38};
      8'd3:    w = {REG_SAMPLING, 8'h00};
      8'd4:    w = {REG_LINE_L,   8'h17};
      8'd5:    w = {REG_LINE_R,   8'h17};
      8'd6:    w = {REG_HP_L,     1'b0, vol};
      8'd7:    w = {REG_HP_R,     1'b0, vol};
      8'd8:    w = {REG_ACTIVE,   8'h01};
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/codec_cfg_rom.sv
// Combinational configuration table: index + live volume -> 16-bit codec word.
module codec_cfg_rom
  import codec_cfg_pkg::*;
#(
  parameter int unsigned ROM_DEPTH = 9,
  parameter int unsigned VOL_IDX_L = 6,
  parameter int unsigned VOL_IDX_R = 7,
  localparam int unsigned IDX_W = $clog2(ROM_DEPTH)
) (
  input  logic [IDX_W-1:0] idx,
  input  logic [6:0]       volume,
  output logic [15:0]      word
);

  // Volume words always reflect the current volume code, wherever they sit in the table
  always_comb begin
    word = 16'h0000;
    if (idx == IDX_W'(VOL_IDX_L)) begin
      word = {REG_HP_L, 1'b0, volume};
    end else if (idx == IDX_W'(VOL_IDX_R)) begin
      word = {REG_HP_R, 1'b0, volume};
    end else begin
      word = cfg_default_word(8'(idx), volume);
    end
  end

endmodule

// File: rtl/codec_cfg_seq.sv
// Audio codec power-up / configuration sequencer driving a two-wire serial controller.
// Optional feature: define CODEC_CFG_RETRY_EN to retry a NACKed or timed-out word up
// to MAX_RETRY times before declaring failure.
module codec_cfg_seq
  import codec_cfg_pkg::*;
#(
  parameter int unsigned CLK_DIV_W     = 11,
  parameter int unsigned ROM_DEPTH     = 9,
  parameter logic [7:0]  DEV_ADDR      = 8'h34,
  parameter int unsigned VOL_IDX_L     = 6,
  parameter int unsigned VOL_IDX_R     = 7,
  parameter logic [6:0]  VOL_DEFAULT   = 7'h60,
  parameter int unsigned VOL_STEP      = 5,
  parameter int unsigned TIMEOUT_TICKS = 15,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic                         CLOCK,
  input  logic                         RESET,
  input  logic                         start,
  input  logic                         vol_up,
  input  logic                         vol_dn,
  input  logic                         i2c_end,
  input  logic                         i2c_ack,
  output logic                         i2c_go,
  output logic [23:0]                  i2c_data,
  output logic                         clk_tick,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [6:0]                   volume,
  output logic [$clog2(ROM_DEPTH)-1:0] idx
);

  localparam int unsigned IDX_W = $clog2(ROM_DEPTH);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [CLK_DIV_W-1:0] DIV_LAST = {CLK_DIV_W{1'b1}};
  localparam logic [CLK_DIV_W-1:0] DIV_PRE  = DIV_LAST - CLK_DIV_W'(1);
  localparam logic [TO_W-1:0]      TO_LAST  = TO_W'(TIMEOUT_TICKS - 1);

  // Reject table layouts the sequencer cannot walk
  if (VOL_IDX_L >= ROM_DEPTH || VOL_IDX_R >= ROM_DEPTH || MAX_RETRY == 0) begin : g_bad_param
    $error("codec_cfg_seq: invalid parameter set");
  end

  logic [CLK_DIV_W-1:0] div_r;
  logic                 tick_r;
  state_e               state_r;
  mode_e                mode_r;
  logic [IDX_W-1:0]     idx_r;
  logic [TO_W-1:0]      to_cnt_r;
  logic [23:0]          data_r;
  logic                 go_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 error_r;
  logic [6:0]           volume_r;
  logic                 vol_pending_r;
  logic [15:0]          rom_word_s;
  logic                 vol_accept_s;
  logic [7:0]           vol_sum_s;
  logic [7:0]           vol_diff_s;
`ifdef CODEC_CFG_RETRY_EN
  localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  logic [RETRY_W-1:0]   retry_r;
`endif

  codec_cfg_rom #(
    .ROM_DEPTH (ROM_DEPTH),
    .VOL_IDX_L (VOL_IDX_L),
    .VOL_IDX_R (VOL_IDX_R)
  ) u_rom (
    .idx    (idx_r),
    .volume (volume_r),
    .word   (rom_word_s)
  );

  // Saturating volume arithmetic and request acceptance (simultaneous up/down cancels)
  always_comb begin
    vol_sum_s    = {1'b0, volume_r} + 8'(VOL_STEP);
    vol_diff_s   = {1'b0, volume_r} - 8'(VOL_STEP);
    vol_accept_s = vol_up ^ vol_dn;
  end

  // Free-running pacing divider; tick is registered to line up with the all-ones count
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      div_r  <= '0;
      tick_r <= 1'b0;
    end else begin
      div_r  <= div_r + CLK_DIV_W'(1);
      tick_r <= (div_r == DIV_PRE);
    end
  end

  // Volume register: applied immediately, the write-out is deferred by the sequencer
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      volume_r <= VOL_DEFAULT;
    end else if (vol_up && !vol_dn) begin
      volume_r <= (vol_sum_s > 8'd127) ? 7'd127 : vol_sum_s[6:0];
    end else if (vol_dn && !vol_up) begin
      volume_r <= vol_diff_s[7] ? 7'd0 : vol_diff_s[6:0];
    end
  end

  // Sequencer FSM with registered handshake and status outputs
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_r       <= ST_IDLE;
      mode_r        <= MODE_FULL;
      idx_r         <= '0;
      to_cnt_r      <= '0;
      data_r        <= 24'h000000;
      go_r          <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      error_r       <= 1'b0;
      vol_pending_r <= 1'b0;
`ifdef CODEC_CFG_RETRY_EN
      retry_r       <= '0;
`endif
    end else begin
      go_r <= 1'b0;
      if (vol_accept_s) begin
        vol_pending_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            idx_r   <= '0;
            mode_r  <= MODE_FULL;
            busy_r  <= 1'b1;
            state_r <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          data_r  <= {DEV_ADDR, rom_word_s};
`ifdef CODEC_CFG_RETRY_EN
          retry_r <= '0;
`endif
          state_r <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (tick_r) begin
            go_r     <= 1'b1;
            to_cnt_r <= '0;
            state_r  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (i2c_end && i2c_ack) begin
            state_r <= ST_NEXT;
          end else if (i2c_end || (tick_r && (to_cnt_r == TO_LAST))) begin
`ifdef CODEC_CFG_RETRY_EN
            if (retry_r < RETRY_MAX) begin
              retry_r <= retry_r + RETRY_W'(1);
              state_r <= ST_ISSUE;
            end else begin
              state_r <= ST_FAIL;
            end
`else
            state_r <= ST_FAIL;
`endif
          end else if (tick_r) begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
          end
        end
        ST_NEXT: begin
`ifdef CODEC_CFG_RETRY_EN
          retry_r <= '0;
`endif
          if (mode_r == MODE_FULL) begin
            if (idx_r == IDX_W'(ROM_DEPTH - 1)) begin
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              idx_r   <= idx_r + IDX_W'(1);
              state_r <= ST_LOAD;
            end
          end else begin
            if (idx_r == IDX_W'(VOL_IDX_L)) begin
              idx_r   <= IDX_W'(VOL_IDX_R);
              state_r <= ST_LOAD;
            end else begin
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= ST_DONE;
            end
          end
        end
        ST_FAIL: begin
          error_r <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= ST_ERR;
        end
        ST_DONE: begin
          if (start) begin
            idx_r   <= '0;
            mode_r  <= MODE_FULL;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            state_r <= ST_LOAD;
          end else if (vol_pending_r) begin
            // A request arriving in this very cycle stays pending for the next pass
            vol_pending_r <= vol_accept_s;
            idx_r         <= IDX_W'(VOL_IDX_L);
            mode_r        <= MODE_VOL;
            busy_r        <= 1'b1;
            done_r        <= 1'b0;
            state_r       <= ST_LOAD;
          end
        end
        ST_ERR: begin
          if (start) begin
            error_r <= 1'b0;
            idx_r   <= '0;
            mode_r  <= MODE_FULL;
            busy_r  <= 1'b1;
            state_r <= ST_LOAD;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign i2c_go   = go_r;
  assign i2c_data = data_r;
  assign clk_tick = tick_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign error    = error_r;
  assign volume   = volume_r;
  assign idx      = idx_r;

endmodule

// File: tb/tb_codec_cfg_seq.sv
// Self-checking bench for codec_cfg_seq (randomised controller latency and volume requests).
module tb_codec_cfg_seq;

  logic        CLOCK, RESET, start, vol_up, vol_dn, i2c_end, i2c_ack;
  logic        i2c_go, clk_tick, busy, done, error;
  logic [23:0] i2c_data;
  logic [6:0]  volume;
  logic [3:0]  idx;

  codec_cfg_seq #(.CLK_DIV_W(4)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .start(start), .vol_up(vol_up), .vol_dn(vol_dn),
    .i2c_end(i2c_end), .i2c_ack(i2c_ack), .i2c_go(i2c_go), .i2c_data(i2c_data),
    .clk_tick(clk_tick), .busy(busy), .done(done), .error(error), .volume(volume), .idx(idx)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  int          tests_run, tests_failed;
  int          cyc, last_go_cyc, tick_viol;
  logic        prev_tick;
  logic [23:0] go_log[$];
  logic [23:0] exp_q[$];
  bit          silent_all;
  logic [23:0] silent_word, nack_word;
  int          nack_left;
  int          vol_m;
  logic [15:0] ref_tab [9];

  // Expected 24-bit transaction for table entry i at volume vol
  function automatic logic [23:0] model_word(input int i, input int vol);
    logic [6:0] v;
    v = vol[6:0];
    if (i == 6) return {8'h34, 8'h04, 1'b0, v};
    if (i == 7) return {8'h34, 8'h06, 1'b0, v};
    return {8'h34, ref_tab[i]};
  endfunction

  function automatic int model_up(input int v);
    return (v + 5 > 127) ? 127 : v + 5;
  endfunction

  function automatic int model_dn(input int v);
    return (v - 5 < 0) ? 0 : v - 5;
  endfunction

  // Transaction monitor: logs every i2c_go and whether a tick preceded it
  always @(posedge CLOCK) begin
    #1;
    cyc = cyc + 1;
    if (i2c_go === 1'b1) begin
      go_log.push_back(i2c_data);
      last_go_cyc = cyc;
      if (prev_tick !== 1'b1) tick_viol = tick_viol + 1;
    end
    prev_tick = clk_tick;
  end

  // Serial controller model: random latency, optional NACKs or silence
  initial begin : responder
    int lat;
    bit ack;
    i2c_end = 1'b0;
    i2c_ack = 1'b0;
    forever begin
      @(posedge CLOCK); #1;
      if (i2c_go === 1'b1 && !silent_all && i2c_data !== silent_word) begin
        ack = 1'b1;
        if (i2c_data === nack_word && nack_left > 0) begin
          ack = 1'b0;
          nack_left = nack_left - 1;
        end
        lat = int'($urandom_range(1, 5));
        repeat (lat) @(posedge CLOCK);
        #1;
        i2c_end = 1'b1;
        i2c_ack = ack;
        @(posedge CLOCK); #1;
        i2c_end = 1'b0;
        i2c_ack = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic pulse(input bit s, input bit u, input bit d);
    start = s; vol_up = u; vol_dn = d;
    @(posedge CLOCK); #1;
    start = 1'b0; vol_up = 1'b0; vol_dn = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    repeat (3) @(posedge CLOCK);
    #1;
    RESET = 1'b1;
    vol_m = 96;
    silent_all = 1'b0; silent_word = 24'hFFFFFF; nack_word = 24'hFFFFFF; nack_left = 0;
  endtask

  task automatic wait_quiet(input int budget, output bit to);
    int stable;
    stable = 0;
    to = 1'b1;
    for (int n = 0; n < budget; n++) begin
      @(posedge CLOCK); #1;
      if (done === 1'b1 || error === 1'b1) stable = stable + 1; else stable = 0;
      if (stable >= 4) begin to = 1'b0; break; end
    end
  endtask

  task automatic wait_gos(input int n, input int budget, output bit to);
    to = 1'b1;
    for (int k = 0; k < budget; k++) begin
      if (go_log.size() >= n) begin to = 1'b0; break; end
      @(posedge CLOCK); #1;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge CLOCK);
    #1;
    tests_run++; if (i2c_go !== 1'b0) begin tests_failed++; $display("FAIL reset_go got %b exp 0", i2c_go); end
    tests_run++; if (i2c_data !== 24'h0) begin tests_failed++; $display("FAIL reset_data got %06h exp 000000", i2c_data); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b exp 0", done); end
    tests_run++; if (error !== 1'b0) begin tests_failed++; $display("FAIL reset_error got %b exp 0", error); end
    tests_run++; if (volume !== 7'h60) begin tests_failed++; $display("FAIL reset_volume got %02h exp 60", volume); end
    tests_run++; if (idx !== 4'd0) begin tests_failed++; $display("FAIL reset_idx got %0d exp 0", idx); end
    tests_run++; if (clk_tick !== 1'b0) begin tests_failed++; $display("FAIL reset_tick got %b exp 0", clk_tick); end
    RESET = 1'b1;
    vol_m = 96;
  endtask

  task automatic test_full_sequence();
    bit to;
    go_log.delete(); exp_q.delete(); tick_viol = 0;
    for (int i = 0; i < 9; i++) exp_q.push_back(model_word(i, vol_m));
    pulse(1'b1, 1'b0, 1'b0);
    wait_quiet(2000, to);
    tests_run++; if (to) begin tests_failed++; $display("FAIL full_timeout got busy=%b exp done", busy); end
    tests_run++; if (go_log.size() != exp_q.size()) begin tests_failed++; $display("FAIL full_count got %0d exp %0d", go_log.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < go_log.size(); i++) begin
      tests_run++; if (go_log[i] !== exp_q[i]) begin tests_failed++; $display("FAIL full_word[%0d] got %06h exp %06h", i, go_log[i], exp_q[i]); end
    end
    tests_run++; if (tick_viol != 0) begin tests_failed++; $display("FAIL full_tick_align got %0d untimed gos exp 0", tick_viol); end
    tests_run++; if (done !== 1'b1 || error !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL full_status got done=%b error=%b busy=%b exp 1 0 0", done, error, busy); end
    tests_run++; if (idx !== 4'd8) begin tests_failed++; $display("FAIL full_idx got %0d exp 8", idx); end
  endtask

  task automatic test_volume_saturation();
    bit to;
    for (int s = 0; s < 7; s++) begin
      go_log.delete(); exp_q.delete();
      pulse(1'b0, 1'b1, 1'b0);
      vol_m = model_up(vol_m);
      exp_q.push_back(model_word(6, vol_m)); exp_q.push_back(model_word(7, vol_m));
      wait_quiet(400, to);
      tests_run++; if (to) begin tests_failed++; $display("FAIL volsat_timeout step %0d got busy=%b exp done", s, busy); end
      tests_run++; if (volume !== vol_m[6:0]) begin tests_failed++; $display("FAIL volsat_value step %0d got %0d exp %0d", s, volume, vol_m); end
      tests_run++; if (go_log.size() != 2) begin tests_failed++; $display("FAIL volsat_count step %0d got %0d exp 2", s, go_log.size()); end
      for (int i = 0; i < 2 && i < go_log.size(); i++) begin
        tests_run++; if (go_log[i] !== exp_q[i]) begin tests_failed++; $display("FAIL volsat_word step %0d[%0d] got %06h exp %06h", s, i, go_log[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_random_volume();
    bit to;
    int r;
    for (int it = 0; it < 8; it++) begin
      r = int'($urandom_range(0, 2));
      go_log.delete(); exp_q.delete();
      if (r == 0) begin pulse(1'b0, 1'b1, 1'b0); vol_m = model_up(vol_m); end
      else if (r == 1) begin pulse(1'b0, 1'b0, 1'b1); vol_m = model_dn(vol_m); end
      else pulse(1'b0, 1'b1, 1'b1);
      if (r != 2) begin exp_q.push_back(model_word(6, vol_m)); exp_q.push_back(model_word(7, vol_m)); end
      wait_quiet(400, to);
      tests_run++; if (to) begin tests_failed++; $display("FAIL randvol_timeout iter %0d got busy=%b exp done", it, busy); end
      tests_run++; if (volume !== vol_m[6:0]) begin tests_failed++; $display("FAIL randvol_value iter %0d got %0d exp %0d", it, volume, vol_m); end
      tests_run++; if (go_log.size() != exp_q.size()) begin tests_failed++; $display("FAIL randvol_count iter %0d got %0d exp %0d", it, go_log.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < go_log.size(); i++) begin
        tests_run++; if (go_log[i] !== exp_q[i]) begin tests_failed++; $display("FAIL randvol_word iter %0d[%0d] got %06h exp %06h", it, i, go_log[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_busy_volume();
    bit to;
    do_reset();
    go_log.delete(); exp_q.delete();
    pulse(1'b1, 1'b0, 1'b0);
    wait_gos(1, 300, to);
    tests_run++; if (to) begin tests_failed++; $display("FAIL busyvol_first_go got %0d gos exp 1", go_log.size()); end
    pulse(1'b0, 1'b0, 1'b1);
    vol_m = model_dn(vol_m);
    wait_gos(2, 300, to);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) exp_q.push_back(model_word(i, vol_m));
    exp_q.push_back(model_word(6, vol_m)); exp_q.push_back(model_word(7, vol_m));
    wait_quiet(3000, to);
    tests_run++; if (to) begin tests_failed++; $display("FAIL busyvol_timeout got busy=%b exp done", busy); end
    tests_run++; if (volume !== vol_m[6:0]) begin tests_failed++; $display("FAIL busyvol_value got %02h exp %02h", volume, vol_m); end
    tests_run++; if (go_log.size() != exp_q.size()) begin tests_failed++; $display("FAIL busyvol_count got %0d exp %0d", go_log.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < go_log.size(); i++) begin
      tests_run++; if (go_log[i] !== exp_q[i]) begin tests_failed++; $display("FAIL busyvol_word[%0d] got %06h exp %06h", i, go_log[i], exp_q[i]); end
    end
  endtask

  task automatic test_nack();
    bit to;
    do_reset();
    nack_word = 24'h341000; nack_left = 2;
    go_log.delete(); exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(model_word(i, vol_m));
`ifdef CODEC_CFG_RETRY_EN
    exp_q.push_back(model_word(3, vol_m)); exp_q.push_back(model_word(3, vol_m));
    for (int i = 4; i < 9; i++) exp_q.push_back(model_word(i, vol_m));
`endif
    pulse(1'b1, 1'b0, 1'b0);
    wait_quiet(3000, to);
    repeat (100) @(posedge CLOCK);
    #1;
    tests_run++; if (to) begin tests_failed++; $display("FAIL nack_timeout got busy=%b exp settled", busy); end
    tests_run++; if (go_log.size() != exp_q.size()) begin tests_failed++; $display("FAIL nack_count got %0d exp %0d", go_log.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < go_log.size(); i++) begin
      tests_run++; if (go_log[i] !== exp_q[i]) begin tests_failed++; $display("FAIL nack_word[%0d] got %06h exp %06h", i, go_log[i], exp_q[i]); end
    end
`ifdef CODEC_CFG_RETRY_EN
    tests_run++; if (done !== 1'b1 || error !== 1'b0) begin tests_failed++; $display("FAIL nack_status got done=%b error=%b exp 1 0", done, error); end
`else
    tests_run++; if (done !== 1'b0 || error !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL nack_status got done=%b error=%b busy=%b exp 0 1 0", done, error, busy); end
`endif
  endtask

  task automatic test_timeout_restart();
    bit to;
    bit seen;
    int delta;
    int n_exp;
    do_reset();
    silent_all = 1'b1;
    go_log.delete();
    pulse(1'b1, 1'b0, 1'b0);
    seen = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      @(posedge CLOCK); #1;
      if (error === 1'b1) begin seen = 1'b1; break; end
    end
    delta = cyc - last_go_cyc;
`ifdef CODEC_CFG_RETRY_EN
    n_exp = 4;
`else
    n_exp = 1;
`endif
    tests_run++; if (!seen) begin tests_failed++; $display("FAIL timeout_error got error=%b exp 1", error); end
    tests_run++; if (delta < 236 || delta > 246) begin tests_failed++; $display("FAIL timeout_latency got %0d cycles exp 241 (+/-5)", delta); end
    tests_run++; if (go_log.size() != n_exp) begin tests_failed++; $display("FAIL timeout_count got %0d exp %0d", go_log.size(), n_exp); end
    for (int i = 0; i < go_log.size(); i++) begin
      tests_run++; if (go_log[i] !== 24'h340C00) begin tests_failed++; $display("FAIL timeout_word[%0d] got %06h exp 340c00", i, go_log[i]); end
    end
    silent_all = 1'b0;
    go_log.delete();
    pulse(1'b1, 1'b0, 1'b0);
    tests_run++; if (error !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("FAIL restart_clear got error=%b busy=%b exp 0 1", error, busy); end
    wait_quiet(3000, to);
    tests_run++; if (to || done !== 1'b1) begin tests_failed++; $display("FAIL restart_done got done=%b exp 1", done); end
    tests_run++; if (go_log.size() != 9) begin tests_failed++; $display("FAIL restart_count got %0d exp 9", go_log.size()); end
    if (go_log.size() > 0) begin
      tests_run++; if (go_log[0] !== 24'h340C00) begin tests_failed++; $display("FAIL restart_first got %06h exp 340c00", go_log[0]); end
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    do_reset();
    silent_word = 24'h340217;
    go_log.delete();
    pulse(1'b1, 1'b0, 1'b0);
    wait_gos(6, 600, to);
    tests_run++; if (to) begin tests_failed++; $display("FAIL midrst_reach got %0d gos exp 6", go_log.size()); end
    repeat (3) @(posedge CLOCK);
    #1;
    pulse(1'b0, 1'b1, 1'b0);
    tests_run++; if (busy !== 1'b1 || idx !== 4'd5) begin tests_failed++; $display("FAIL midrst_pre got busy=%b idx=%0d exp 1 5", busy, idx); end
    RESET = 1'b0;
    #1;
    tests_run++; if (i2c_go !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin tests_failed++; $display("FAIL midrst_flags got go=%b busy=%b done=%b error=%b exp 0 0 0 0", i2c_go, busy, done, error); end
    tests_run++; if (i2c_data !== 24'h0 || idx !== 4'd0) begin tests_failed++; $display("FAIL midrst_data got data=%06h idx=%0d exp 000000 0", i2c_data, idx); end
    tests_run++; if (volume !== 7'h60) begin tests_failed++; $display("FAIL midrst_volume got %02h exp 60", volume); end
    @(posedge CLOCK); #1;
    RESET = 1'b1;
    vol_m = 96;
    silent_word = 24'hFFFFFF;
    go_log.delete(); exp_q.delete();
    for (int i = 0; i < 9; i++) exp_q.push_back(model_word(i, vol_m));
    pulse(1'b1, 1'b0, 1'b0);
    wait_quiet(3000, to);
    tests_run++; if (to) begin tests_failed++; $display("FAIL midrst_restart got busy=%b exp done", busy); end
    tests_run++; if (go_log.size() != exp_q.size()) begin tests_failed++; $display("FAIL midrst_count got %0d exp %0d", go_log.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < go_log.size(); i++) begin
      tests_run++; if (go_log[i] !== exp_q[i]) begin tests_failed++; $display("FAIL midrst_word[%0d] got %06h exp %06h", i, go_log[i], exp_q[i]); end
    end
  endtask

  // Global time limit so the bench always terminates
  initial begin
    #600000;
    $display("FAIL watchdog got no completion exp summary before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run = 0; tests_failed = 0; cyc = 0; last_go_cyc = 0; tick_viol = 0; prev_tick = 1'b0;
    ref_tab[0] = 16'h0C00; ref_tab[1] = 16'h0EC2; ref_tab[2] = 16'h0838;
    ref_tab[3] = 16'h1000; ref_tab[4] = 16'h0017; ref_tab[5] = 16'h0217;
    ref_tab[6] = 16'h0000; ref_tab[7] = 16'h0000; ref_tab[8] = 16'h1201;
    RESET = 1'b0; start = 1'b0; vol_up = 1'b0; vol_dn = 1'b0;
    silent_all = 1'b0; silent_word = 24'hFFFFFF; nack_word = 24'hFFFFFF; nack_left = 0;
    vol_m = 96;
    test_reset();
    test_full_sequence();
    test_volume_saturation();
    test_random_volume();
    test_busy_volume();
    test_nack();
    test_timeout_restart();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
